mux_arb_n_to_1: RTL

MUX_ARB_N_TO_1 -- requirements
Module: mux_arb_n_to_1

---
 rtl/mux_arb_n_to_1.sv | 103 ++++++++++
 1 files changed

// File: rtl/mux_arb_n_to_1.sv
// N-to-1 valid/ready multiplexer with a single registered output stage.
// Grants either a fixed channel (mode=0) or round-robin from ptr (mode=1).
module mux_arb_n_to_1 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_src_q;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             free;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    // Grant selection. Round-robin scans [ptr, N-1] first, then [0, ptr-1].
    always_comb begin
        free    = !out_valid_q || out_ready;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!gnt_any && in_valid[i] && (SELW'(i) >= ptr_q)) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!gnt_any && in_valid[i] && (SELW'(i) < ptr_q)) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            // A sel value with no matching channel (sel >= N) grants nothing.
            for (int unsigned i = 0; i < N; i++) begin
                if ((sel == SELW'(i)) && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end
        if (rst || !free) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                in_ready[i] = gnt_any;
                gnt_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any && mode) begin
            ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (gnt_any) begin
                out_valid_q <= 1'b1;
                out_data_q  <= gnt_data;
                out_src_q   <= gnt_idx;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
